// File: rtl/stalin_sort_pkg.sv
// Shared compare modes and keep/drop decision for the streaming Stalin sort.
package stalin_sort_pkg;

    localparam logic ORDER_ASC  = 1'b0;
    localparam logic ORDER_DESC = 1'b1;
    localparam logic EQ_KEEP    = 1'b0;
    localparam logic EQ_DROP    = 1'b1;

    // lt/eq are in_data relative to the running extreme, already sign-resolved.
    function automatic logic keep_beat(input logic lt, input logic eq,
                                       input logic order, input logic eq_mode);
        logic gt;
        gt = !lt && !eq;
        if (order == ORDER_DESC)
            return (eq_mode == EQ_DROP) ? lt : (lt || eq);
        else
            return (eq_mode == EQ_DROP) ? gt : (gt || eq);
    endfunction

endpackage

// File: rtl/stalin_sort_fifo.sv
// Synchronous FIFO with two in-order push ports, one pop port and an occupancy count.
module stalin_sort_fifo #(
    parameter int unsigned W     = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push0_i,
    input  logic [W-1:0]               d0_i,
    input  logic                       push1_i,
    input  logic [W-1:0]               d1_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

    // push1 lands behind push0 when both fire in the same cycle
    always_ff @(posedge clk) begin
        if (push0_i)
            mem_q[wr_q] <= d0_i;
        if (push1_i)
            mem_q[wr_q + AW'(push0_i)] <= d1_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push0_i) + AW'(push1_i);
            rd_q    <= rd_q + AW'(do_pop);
            count_q <= count_q + CW'(push0_i) + CW'(push1_i) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/stalin_sort_stream.sv
// Streaming frame-based Stalin sort: drops out-of-order beats, emits survivors with end-of-frame.
// Optional per-frame statistics enabled by defining STALIN_SORT_STREAM_STATS_EN.
module stalin_sort_stream
    import stalin_sort_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DESCENDING = 0,
    parameter int unsigned STRICT     = 0,
    parameter int unsigned SIGNED     = 0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
`ifdef STALIN_SORT_STREAM_STATS_EN
    ,
    output logic             stat_valid,
    output logic [CNT_W-1:0] stat_kept,
    output logic [CNT_W-1:0] stat_dropped
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } entry_t;

    logic [WIDTH-1:0] ext_q, ext_d, held_q, held_d;
    logic             held_v_q, held_v_d, first_q, first_d;
    logic             accept, keep, lt, eq;
    logic             push0, push1;
    entry_t           e0, e1, head;
    logic [CW-1:0]    count;

    assign in_ready = !rst && (count <= CW'(FIFO_DEPTH - 2));
    assign accept   = in_valid && in_ready;

    assign lt   = (SIGNED != 0) ? ($signed(in_data) < $signed(ext_q)) : (in_data < ext_q);
    assign eq   = (in_data == ext_q);
    assign keep = first_q || keep_beat(lt, eq, (DESCENDING != 0) ? ORDER_DESC : ORDER_ASC,
                                       (STRICT != 0) ? EQ_DROP : EQ_KEEP);

    // Survivors are held back one step so the final one can carry last=1.
    always_comb begin
        ext_d    = ext_q;
        held_d   = held_q;
        held_v_d = held_v_q;
        first_d  = first_q;
        push0    = 1'b0;
        push1    = 1'b0;
        e0       = '0;
        e1       = '0;
        if (accept) begin
            if (keep) begin
                ext_d    = in_data;
                held_d   = in_data;
                held_v_d = 1'b1;
                first_d  = 1'b0;
                if (held_v_q) begin
                    push0 = 1'b1;
                    e0    = '{data: held_q, last: 1'b0};
                    if (in_last) begin
                        push1 = 1'b1;
                        e1    = '{data: in_data, last: 1'b1};
                    end
                end else if (in_last) begin
                    push0 = 1'b1;
                    e0    = '{data: in_data, last: 1'b1};
                end
            end else if (in_last) begin
                push0 = 1'b1;
                e0    = '{data: held_q, last: 1'b1};
            end
            if (in_last) begin
                held_v_d = 1'b0;
                first_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q    <= '0;
            held_q   <= '0;
            held_v_q <= 1'b0;
            first_q  <= 1'b1;
        end else begin
            ext_q    <= ext_d;
            held_q   <= held_d;
            held_v_q <= held_v_d;
            first_q  <= first_d;
        end
    end

    stalin_sort_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push0_i (push0),
        .d0_i    (e0),
        .push1_i (push1),
        .d1_i    (e1),
        .pop_i   (out_valid && out_ready),
        .head_o  (head),
        .count_o (count)
    );

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? head.data : '0;
    assign out_last  = out_valid ? head.last : 1'b0;

`ifdef STALIN_SORT_STREAM_STATS_EN
    logic [CNT_W-1:0] kept_q, dropped_q, kept_n, dropped_n;
    logic [CNT_W-1:0] stat_kept_q, stat_dropped_q;
    logic             stat_valid_q;

    always_comb begin
        kept_n    = kept_q;
        dropped_n = dropped_q;
        if (keep && kept_q != '1)
            kept_n = kept_q + 1'b1;
        if (!keep && dropped_q != '1)
            dropped_n = dropped_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kept_q         <= '0;
            dropped_q      <= '0;
            stat_kept_q    <= '0;
            stat_dropped_q <= '0;
            stat_valid_q   <= 1'b0;
        end else begin
            stat_valid_q <= 1'b0;
            if (accept) begin
                if (in_last) begin
                    stat_valid_q   <= 1'b1;
                    stat_kept_q    <= kept_n;
                    stat_dropped_q <= dropped_n;
                    kept_q         <= '0;
                    dropped_q      <= '0;
                end else begin
                    kept_q    <= kept_n;
                    dropped_q <= dropped_n;
                end
            end
        end
    end

    assign stat_valid   = stat_valid_q;
    assign stat_kept    = stat_kept_q;
    assign stat_dropped = stat_dropped_q;
`endif

endmodule
